// File: rtl/eka_mem_responder.sv
// eka_mem_responder: word RAM serving Eka fetch and data ports with wait states.
// Optional feature macro: ACCESS_FAULT_EN (adds access_fault, blocks out-of-range access).
module eka_mem_responder #(
  parameter int    ADDR_WIDTH      = 32,
  parameter int    MEM_DEPTH_WORDS = 1024,
  parameter int    RD_WAIT         = 1,
  parameter int    WR_WAIT         = 1,
  parameter string INIT_FILE       = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           mem_wr_data,
  input  logic                  mem_wr,
  input  logic                  mem_rd,
  output logic [31:0]           mem_rd_data,
  output logic                  data_stall
`ifdef ACCESS_FAULT_EN
  ,
  output logic                  access_fault
`endif
);

  localparam int          AW     = $clog2(MEM_DEPTH_WORDS);
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [3:0]  RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0]  WR_CNT = 4'(WR_WAIT);

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_EXEC,
    S_DATA,
    S_DATA_DONE
  } state_t;

  logic [31:0]   r_mem [MEM_DEPTH_WORDS];

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_iidx;
  logic [AW-1:0] r_didx;
  logic [31:0]   r_wdata;
  logic          r_store;
  logic [31:0]   r_instr;
  logic          r_ivalid;
  logic [31:0]   r_rd_data;
  logic          r_ifault;
  logic          r_dfault;

  state_t        w_state_nxt;
  logic [3:0]    w_cnt_nxt;
  logic [AW-1:0] w_iidx_nxt;
  logic [AW-1:0] w_didx_nxt;
  logic [31:0]   w_wdata_nxt;
  logic          w_store_nxt;
  logic [31:0]   w_instr_nxt;
  logic          w_ivalid_nxt;
  logic [31:0]   w_rd_data_nxt;
  logic          w_ifault_nxt;
  logic          w_dfault_nxt;
  logic          w_mem_we;
  logic          w_stall;
  logic          w_req;
  logic          w_ia_bad;
  logic          w_da_bad;
  logic          w_unused;

  assign w_req = mem_rd | mem_wr;

`ifdef ACCESS_FAULT_EN
  logic r_fault;
  logic w_fault_set;

  assign w_ia_bad = |inst_addr[ADDR_WIDTH-1:AW+2];
  assign w_da_bad = |data_addr[31:AW+2];
  assign w_unused = ^{inst_addr[1:0], data_addr[1:0]};

  assign w_fault_set = ((r_state == S_FETCH) & w_ia_bad)
                     | ((r_state == S_EXEC) & w_req & w_da_bad);

  // Sticky fault flag, only cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign access_fault = r_fault;
`else
  assign w_ia_bad = 1'b0;
  assign w_da_bad = 1'b0;
  assign w_unused = ^{inst_addr[ADDR_WIDTH-1:AW+2], inst_addr[1:0],
                      data_addr[31:AW+2], data_addr[1:0]};
`endif

  // RAM write port; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_didx] <= r_wdata;
    end
  end

  // Next-state and combinational outputs for the access sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_iidx_nxt    = r_iidx;
    w_didx_nxt    = r_didx;
    w_wdata_nxt   = r_wdata;
    w_store_nxt   = r_store;
    w_instr_nxt   = r_instr;
    w_ivalid_nxt  = r_ivalid;
    w_rd_data_nxt = r_rd_data;
    w_ifault_nxt  = r_ifault;
    w_dfault_nxt  = r_dfault;
    w_mem_we      = 1'b0;
    w_stall       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_iidx_nxt   = inst_addr[AW+1:2];
        w_ifault_nxt = w_ia_bad;
        w_cnt_nxt    = RD_CNT;
        w_state_nxt  = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_instr_nxt  = r_ifault ? NOP : r_mem[r_iidx];
          w_ivalid_nxt = 1'b1;
          w_state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_req) begin
          w_stall      = 1'b1;
          w_didx_nxt   = data_addr[AW+1:2];
          w_wdata_nxt  = mem_wr_data;
          w_store_nxt  = mem_wr;
          w_dfault_nxt = w_da_bad;
          w_cnt_nxt    = mem_wr ? WR_CNT : RD_CNT;
          w_state_nxt  = S_DATA;
        end else begin
          w_ivalid_nxt = 1'b0;
          w_state_nxt  = S_FETCH;
        end
      end
      S_DATA: begin
        w_stall = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          if (r_store) begin
            w_mem_we = ~r_dfault;
          end else begin
            w_rd_data_nxt = r_dfault ? 32'h0 : r_mem[r_didx];
          end
          w_state_nxt = S_DATA_DONE;
        end
      end
      S_DATA_DONE: begin
        w_ivalid_nxt = 1'b0;
        w_state_nxt  = S_FETCH;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= 4'd0;
      r_iidx    <= '0;
      r_didx    <= '0;
      r_wdata   <= 32'h0;
      r_store   <= 1'b0;
      r_instr   <= NOP;
      r_ivalid  <= 1'b0;
      r_rd_data <= 32'h0;
      r_ifault  <= 1'b0;
      r_dfault  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_iidx    <= w_iidx_nxt;
      r_didx    <= w_didx_nxt;
      r_wdata   <= w_wdata_nxt;
      r_store   <= w_store_nxt;
      r_instr   <= w_instr_nxt;
      r_ivalid  <= w_ivalid_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_ifault  <= w_ifault_nxt;
      r_dfault  <= w_dfault_nxt;
    end
  end

  assign instruction = r_instr;
  assign inst_valid  = r_ivalid;
  assign mem_rd_data = r_rd_data;
  assign data_stall  = w_stall;

endmodule

// File: tb/tb_eka_mem_responder.sv
// tb_eka_mem_responder: transaction-level model plus per-cycle compare.
// Works with or without ACCESS_FAULT_EN defined.
module tb_eka_mem_responder;

  localparam int RDW   = 2;
  localparam int WRW   = 3;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [31:0] data_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [31:0] mem_rd_data;
  logic        data_stall;
`ifdef ACCESS_FAULT_EN
  logic        access_fault;
`endif

  eka_mem_responder #(
    .ADDR_WIDTH(32),
    .MEM_DEPTH_WORDS(DEPTH),
    .RD_WAIT(RDW),
    .WR_WAIT(WRW),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset(reset),
    .inst_addr(inst_addr),
    .instruction(instruction),
    .inst_valid(inst_valid),
    .data_addr(data_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr(mem_wr),
    .mem_rd(mem_rd),
    .mem_rd_data(mem_rd_data),
    .data_stall(data_stall)
`ifdef ACCESS_FAULT_EN
    ,
    .access_fault(access_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int valid_cnt = 0;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    bit          idc;
    logic        stall;
    logic [31:0] rd;
    bit          rdc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  // model state
  logic [31:0] m_mem [int];
  logic [31:0] m_instr;
  bit          m_idc;
  logic [31:0] m_rd;
  bit          m_rdc;
  logic        m_fault;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit bad(input logic [31:0] a);
`ifdef ACCESS_FAULT_EN
    return (a >> (AW + 2)) != 0;
`else
    return a == 32'hFFFF_FFFF && a != a;
`endif
  endfunction

  task automatic model_reset();
    m_instr = NOP;
    m_idc   = 1'b0;
    m_rd    = 32'h0;
    m_rdc   = 1'b0;
    m_fault = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare against the queued expected trace.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (data_stall === 1'b1) stall_cnt++;
    if (inst_valid === 1'b1) valid_cnt++;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ok = (inst_valid === e.valid) && (data_stall === e.stall);
      if (!e.idc && instruction !== e.instr) ok = 1'b0;
      if (!e.rdc && mem_rd_data !== e.rd) ok = 1'b0;
`ifdef ACCESS_FAULT_EN
      if (access_fault !== e.fault) ok = 1'b0;
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle t=%0t valid=%b/%b instr=%h/%h stall=%b/%b rd=%h/%h (got/want)",
                 $time, inst_valid, e.valid, instruction, e.instr,
                 data_stall, e.stall, mem_rd_data, e.rd);
      end
    end
  end

  function automatic exp_t mk(input logic v, input logic [31:0] i,
                              input bit idc, input logic s,
                              input logic [31:0] r, input bit rdc,
                              input logic f);
    exp_t e;
    e.valid = v; e.instr = i; e.idc = idc;
    e.stall = s; e.rd = r; e.rdc = rdc; e.fault = f;
    return e;
  endfunction

  // One instruction: fetch from pc, optional load/store, core retires.
  // Called at 1 time unit after the edge that entered the fetch cycle.
  task automatic run_instr(input logic [31:0] pc, input logic rd,
                           input logic wr, input logic [31:0] da,
                           input logic [31:0] wd);
    logic [31:0] fi;
    bit          fdc;
    bit          fb;
    bit          db;
    logic        f1;
    logic        f2;
    logic [31:0] nrd;
    bit          nrdc;
    int          n;
    int          w;
    inst_addr   = pc;
    mem_rd      = rd;
    mem_wr      = wr;
    data_addr   = da;
    mem_wr_data = wd;
    stall_cnt   = 0;
    valid_cnt   = 0;
    fb  = bad(pc);
    fdc = 1'b0;
    if (fb) fi = NOP;
    else if (m_mem.exists(widx(pc))) fi = m_mem[widx(pc)];
    else begin fi = 32'h0; fdc = 1'b1; end
    f1 = m_fault | fb;
    for (int i = 0; i < RDW + 2; i++)
      exp_q.push_back(mk(1'b0, m_instr, m_idc, 1'b0, m_rd, m_rdc,
                         (i == 0) ? m_fault : f1));
    exp_q.push_back(mk(1'b1, fi, fdc, rd | wr, m_rd, m_rdc, f1));
    n    = RDW + 3;
    nrd  = m_rd;
    nrdc = m_rdc;
    f2   = f1;
    db   = 1'b0;
    if (rd | wr) begin
      db = bad(da);
      f2 = f1 | db;
      if (!wr) begin
        if (db) begin nrd = 32'h0; nrdc = 1'b0; end
        else if (m_mem.exists(widx(da))) begin
          nrd = m_mem[widx(da)]; nrdc = 1'b0;
        end else nrdc = 1'b1;
      end
      w = wr ? WRW : RDW;
      for (int j = 0; j <= w; j++)
        exp_q.push_back(mk(1'b1, fi, fdc, 1'b1, m_rd, m_rdc, f2));
      exp_q.push_back(mk(1'b1, fi, fdc, 1'b0, nrd, nrdc, f2));
      n += w + 2;
    end
    repeat (n) @(posedge clk);
    #1;
    m_instr = fi;
    m_idc   = fdc;
    m_rd    = nrd;
    m_rdc   = nrdc;
    m_fault = f2;
    if (wr && !db) m_mem[widx(da)] = wd;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    inst_addr   = 32'h0;
    data_addr   = 32'h0;
    mem_wr_data = 32'h0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // preload RAM through the store path
    run_instr(32'h40, 1'b0, 1'b1, 32'h000, 32'h0050_0093);
    run_instr(32'h40, 1'b0, 1'b1, 32'h004, 32'h0010_0113);
    run_instr(32'h40, 1'b0, 1'b1, 32'h008, 32'h0020_0193);
    run_instr(32'h40, 1'b0, 1'b1, 32'h00C, 32'h0030_0213);
    run_instr(32'h40, 1'b0, 1'b1, 32'h200, 32'h1111_2222);

    // test 1: reset values, then fetch latency
    reset = 1'b0;
    #1;
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_stall", {31'h0, data_stall}, 32'h0);
`ifdef ACCESS_FAULT_EN
    chk("rst_fault", {31'h0, access_fault}, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    inst_addr = 32'h0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk("t1_valid_lo", {31'h0, inst_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    chk("t1_valid_hi", {31'h0, inst_valid}, 32'h1);
    chk("t1_instr", instruction, 32'h0050_0093);
    chk("t1_stall", {31'h0, data_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("t1_retire", {31'h0, inst_valid}, 32'h0);
    m_instr = 32'h0050_0093;

    // test 2: plain instruction from word 1
    run_instr(32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_vcnt", valid_cnt, 1);
    chk("t2_scnt", stall_cnt, 0);
    chk("t2_instr", instruction, 32'h0010_0113);

    // test 3: store
    run_instr(32'h8, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    chk("t3_scnt", stall_cnt, 2 + WRW);
    chk("t3_instr", instruction, 32'h0020_0193);

    // test 4: load back, unaligned low bits ignored
    run_instr(32'hC, 1'b1, 1'b0, 32'h102, 32'h0);
    chk("t4_scnt", stall_cnt, 2 + RDW);
    chk("t4_rdata", mem_rd_data, 32'hDEAD_BEEF);

    // both requests: store wins, read data untouched
    run_instr(32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D);
    chk("both_scnt", stall_cnt, 2 + WRW);
    chk("both_rdata", mem_rd_data, 32'hDEAD_BEEF);
    run_instr(32'h4, 1'b1, 1'b0, 32'h104, 32'h0);
    chk("both_load", mem_rd_data, 32'hCAFE_F00D);

    // test 5: reset on second data cycle aborts store
    inst_addr   = 32'h8;
    mem_wr      = 1'b1;
    data_addr   = 32'h200;
    mem_wr_data = 32'h55AA_55AA;
    repeat (RDW + 4) @(posedge clk);
    #1;
    chk("t5_in_data", {31'h0, data_stall}, 32'h1);
    reset = 1'b0;
    #1;
    chk("t5_valid", {31'h0, inst_valid}, 32'h0);
    chk("t5_stall", {31'h0, data_stall}, 32'h0);
    chk("t5_instr", instruction, NOP);
    mem_wr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    run_instr(32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("t5_ram", mem_rd_data, 32'h1111_2222);

    // test 6: out-of-range store
    run_instr(32'h4, 1'b0, 1'b1, 32'h0 + 4 * DEPTH, 32'h1234);
    run_instr(32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
`ifdef ACCESS_FAULT_EN
    chk("t6_fault", {31'h0, access_fault}, 32'h1);
    chk("t6_ram0", mem_rd_data, 32'h0050_0093);
    run_instr(32'h8, 1'b1, 1'b0, 32'h4 + 4 * DEPTH, 32'h0);
    chk("t6_fload", mem_rd_data, 32'h0);
    chk("t6_sticky", {31'h0, access_fault}, 32'h1);
`else
    chk("t6_ram0", mem_rd_data, 32'h0000_1234);
    run_instr(32'h8, 1'b1, 1'b0, 32'h4 + 4 * DEPTH, 32'h0);
    chk("t6_wrap", mem_rd_data, 32'h0010_0113);
`endif
    run_instr(32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
